instruction_fetch: RTL and testbench

Fetch stage directly upstream of the main controller. It holds the PC, drives the synchronous instruction ROM, and presents instruction[31:0] to the controller, decoder and executer. It consumes the controller's jr/jmp/jal/branch/nBranch decisions and the executer's zero flag to select the next PC, and records the jal link address. A small FSM covers ROM boot latency, stall, and fault on an illegal target.

---
 rtl/instruction_fetch.sv | 113 +++++++++++
 tb/tb_instruction_fetch.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC register, next-PC selection and ROM drive for the fetch stage
// BOOT covers the one-cycle ROM latency; FAULT latches on an illegal committed target.
module instruction_fetch #(
   parameter int          ADDR_W   = 14,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              jr,
   input  logic              jmp,
   input  logic              jal,
   input  logic              branch,
   input  logic              nBranch,
   input  logic              zero,
   input  logic [31:0]       branchOffset,
   input  logic [31:0]       readData1,
   output logic [ADDR_W-1:0] romAddr,
   input  logic [31:0]       romData,
   output logic [31:0]       instruction,
   output logic [31:0]       pc,
   output logic [31:0]       pcPlus4,
   output logic [31:0]       linkAddr,
   output logic              instValid,
   output logic              fault
);

   typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] link_q, link_d;
   logic        fault_q, fault_d;

   logic [31:0] next_pc;
   logic        taken;
   logic        illegal;
   logic        commit;

   assign pc          = pc_q;
   assign pcPlus4     = pc_q + 32'd4;
   assign linkAddr    = link_q;
   assign fault       = fault_q;
   assign instruction = (state_q == RUN) ? romData : 32'h0000_0000;
   assign commit      = (state_q == RUN) && !stall;

   always_comb begin
      taken = (branch && zero) || (nBranch && !zero);
      if (jr)
         next_pc = readData1;
      else if (jmp || jal)
         next_pc = {pcPlus4[31:28], instruction[25:0], 2'b00};
      else if (taken)
         next_pc = pcPlus4 + (branchOffset << 2);
      else
         next_pc = pcPlus4;
      illegal = (next_pc[1:0] != 2'b00) || (next_pc[31:ADDR_W+2] != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         link_q  <= 32'h0000_0000;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         link_q  <= link_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     if (commit && illegal) state_d = FAULT;
         FAULT:   state_d = FAULT;
         default: state_d = BOOT;
      endcase
   end

   // A faulting commit freezes pc on the offending instruction and leaves the link untouched.
   always_comb begin
      pc_d    = pc_q;
      link_d  = link_q;
      fault_d = fault_q;
      if (commit) begin
         if (illegal) begin
            fault_d = 1'b1;
         end else begin
            pc_d = next_pc;
            if (jal) link_d = pcPlus4;
         end
      end
   end

   always_comb begin
      instValid = 1'b0;
      romAddr   = pc_q[ADDR_W+1:2];
      case (state_q)
         BOOT:    romAddr = RESET_PC[ADDR_W+1:2];
         RUN: begin
            instValid = 1'b1;
            romAddr   = commit ? next_pc[ADDR_W+1:2] : pc_q[ADDR_W+1:2];
         end
         FAULT:   romAddr = pc_q[ADDR_W+1:2];
         default: romAddr = pc_q[ADDR_W+1:2];
      endcase
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed-vector bench for instruction_fetch
// Synchronous ROM model; DUT outputs sampled on the falling edge, inputs driven there too.
module tb_instruction_fetch;

   localparam int ADDR_W = 14;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              stall, jr, jmp, jal, branch, nBranch, zero;
   logic [31:0]       branchOffset, readData1;
   logic [ADDR_W-1:0] romAddr;
   logic [31:0]       romData;
   logic [31:0]       instruction, pc, pcPlus4, linkAddr;
   logic              instValid, fault;

   logic [31:0] rom [0:(1<<ADDR_W)-1];
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   always @(posedge clk) romData <= rom[romAddr];

   instruction_fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .jr(jr), .jmp(jmp), .jal(jal),
      .branch(branch), .nBranch(nBranch), .zero(zero), .branchOffset(branchOffset),
      .readData1(readData1), .romAddr(romAddr), .romData(romData),
      .instruction(instruction), .pc(pc), .pcPlus4(pcPlus4), .linkAddr(linkAddr),
      .instValid(instValid), .fault(fault)
   );

   task automatic idle_inputs();
      stall = 0; jr = 0; jmp = 0; jal = 0; branch = 0; nBranch = 0; zero = 0;
      branchOffset = 32'h0; readData1 = 32'h0;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Leaves the DUT in RUN at pc=0 at a falling edge.
   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      #3;
      vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
      vectors++; if (instValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", instValid); end
      vectors++; if (linkAddr !== 32'h0) begin miscompares++; $display("FAIL reset_link got %h want 0", linkAddr); end
      vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got %b want 0", fault); end
      vectors++; if (instruction !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h want 0", instruction); end
      vectors++; if (pcPlus4 !== 32'h4) begin miscompares++; $display("FAIL reset_pcplus4 got %h want 4", pcPlus4); end
      @(negedge clk);
      rst_n = 1;
      #1;
      vectors++; if (instValid !== 1'b0) begin miscompares++; $display("FAIL boot_valid got %b want 0", instValid); end
      vectors++; if (romAddr !== 14'd0) begin miscompares++; $display("FAIL boot_romaddr got %0d want 0", romAddr); end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vectors++; if (pc !== 32'(4 * i)) begin miscompares++; $display("FAIL seq_pc[%0d] got %h want %h", i, pc, 32'(4 * i)); end
         vectors++; if (instruction !== 32'h1000_0000 + 32'(i)) begin miscompares++; $display("FAIL seq_instr[%0d] got %h want %h", i, instruction, 32'h1000_0000 + 32'(i)); end
         vectors++; if (instValid !== 1'b1) begin miscompares++; $display("FAIL seq_valid[%0d] got %b want 1", i, instValid); end
      end
   endtask

   task automatic test_branch();
      do_reset();
      step(2);
      branch = 1; zero = 1; branchOffset = 32'hFFFF_FFFE;
      @(negedge clk);
      vectors++; if (pc !== 32'h4) begin miscompares++; $display("FAIL beq_taken got %h want 4", pc); end
      idle_inputs();
      @(negedge clk);
      branch = 1; zero = 0; branchOffset = 32'hFFFF_FFFE;
      @(negedge clk);
      vectors++; if (pc !== 32'hC) begin miscompares++; $display("FAIL beq_not_taken got %h want c", pc); end
      do_reset();
      step(2);
      nBranch = 1; zero = 0; branchOffset = 32'd3;
      @(negedge clk);
      vectors++; if (pc !== 32'h18) begin miscompares++; $display("FAIL bne_taken got %h want 18", pc); end
      vectors++; if (instruction !== 32'h1000_0006) begin miscompares++; $display("FAIL bne_instr got %h want 10000006", instruction); end
      nBranch = 1; zero = 1;
      @(negedge clk);
      vectors++; if (pc !== 32'h1C) begin miscompares++; $display("FAIL bne_not_taken got %h want 1c", pc); end
      idle_inputs();
   endtask

   task automatic test_jal_jr();
      do_reset();
      step(4);
      vectors++; if (instruction !== 32'h0C00_0040) begin miscompares++; $display("FAIL jal_instr got %h want 0c000040", instruction); end
      jal = 1;
      @(negedge clk);
      vectors++; if (pc !== 32'h100) begin miscompares++; $display("FAIL jal_pc got %h want 100", pc); end
      vectors++; if (linkAddr !== 32'h14) begin miscompares++; $display("FAIL jal_link got %h want 14", linkAddr); end
      jal = 0; jr = 1; readData1 = 32'h14;
      @(negedge clk);
      vectors++; if (pc !== 32'h14) begin miscompares++; $display("FAIL jr_pc got %h want 14", pc); end
      vectors++; if (linkAddr !== 32'h14) begin miscompares++; $display("FAIL jr_link got %h want 14", linkAddr); end
      jr = 1; jal = 1; readData1 = 32'h40;
      @(negedge clk);
      vectors++; if (pc !== 32'h40) begin miscompares++; $display("FAIL jrjal_pc got %h want 40", pc); end
      vectors++; if (linkAddr !== 32'h18) begin miscompares++; $display("FAIL jrjal_link got %h want 18", linkAddr); end
      idle_inputs();
   endtask

   task automatic test_stall();
      do_reset();
      step(8);
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++; if (pc !== 32'h20) begin miscompares++; $display("FAIL stall_pc[%0d] got %h want 20", i, pc); end
         vectors++; if (instruction !== 32'h1000_0008) begin miscompares++; $display("FAIL stall_instr[%0d] got %h want 10000008", i, instruction); end
         vectors++; if (romAddr !== 14'd8) begin miscompares++; $display("FAIL stall_romaddr[%0d] got %0d want 8", i, romAddr); end
         @(negedge clk);
      end
      stall = 0;
      @(negedge clk);
      vectors++; if (pc !== 32'h24) begin miscompares++; $display("FAIL unstall_pc got %h want 24", pc); end
      vectors++; if (instruction !== 32'h1000_0009) begin miscompares++; $display("FAIL unstall_instr got %h want 10000009", instruction); end
   endtask

   task automatic test_boot_stall();
      idle_inputs();
      rst_n = 0;
      stall = 1;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      vectors++; if (instValid !== 1'b1) begin miscompares++; $display("FAIL bootstall_valid got %b want 1", instValid); end
      vectors++; if (instruction !== 32'h1000_0000) begin miscompares++; $display("FAIL bootstall_instr got %h want 10000000", instruction); end
      stall = 0;
   endtask

   task automatic test_fault_misaligned();
      do_reset();
      jal = 1;
      @(negedge clk);
      vectors++; if (linkAddr !== 32'h4) begin miscompares++; $display("FAIL pre_fault_link got %h want 4", linkAddr); end
      jal = 0; jr = 1; readData1 = 32'h102;
      @(negedge clk);
      vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL misalign_fault got %b want 1", fault); end
      vectors++; if (instValid !== 1'b0) begin miscompares++; $display("FAIL misalign_valid got %b want 0", instValid); end
      vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL misalign_pc got %h want 0", pc); end
      vectors++; if (linkAddr !== 32'h4) begin miscompares++; $display("FAIL misalign_link got %h want 4", linkAddr); end
      jr = 0; jal = 1;
      @(negedge clk);
      vectors++; if (pc !== 32'h0 || linkAddr !== 32'h4 || fault !== 1'b1) begin miscompares++; $display("FAIL fault_sticky got pc=%h link=%h fault=%b want 0/4/1", pc, linkAddr, fault); end
      idle_inputs();
      rst_n = 0;
      #1;
      vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL fault_clear got %b want 0", fault); end
      @(negedge clk);
      rst_n = 1;
      step(2);
      vectors++; if (pc !== 32'h4 || instValid !== 1'b1) begin miscompares++; $display("FAIL restart got pc=%h valid=%b want 4/1", pc, instValid); end
   endtask

   task automatic test_fault_range();
      do_reset();
      step(1);
      jal = 1;
      @(negedge clk);
      vectors++; if (pc !== 32'h4 || linkAddr !== 32'h8) begin miscompares++; $display("FAIL range_pre got pc=%h link=%h want 4/8", pc, linkAddr); end
      jal = 0; jr = 1; readData1 = 32'h0001_0000;
      @(negedge clk);
      vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL range_fault got %b want 1", fault); end
      vectors++; if (pc !== 32'h4) begin miscompares++; $display("FAIL range_pc got %h want 4", pc); end
      #2;
      rst_n = 0;
      #1;
      vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL async_pc got %h want 0", pc); end
      vectors++; if (linkAddr !== 32'h0) begin miscompares++; $display("FAIL async_link got %h want 0", linkAddr); end
      vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL async_fault got %b want 0", fault); end
      vectors++; if (instValid !== 1'b0) begin miscompares++; $display("FAIL async_valid got %b want 0", instValid); end
      idle_inputs();
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 32'h1000_0000 + 32'(i);
      rom[4] = 32'h0C00_0040;
      test_reset();
      test_sequential();
      test_branch();
      test_jal_jr();
      test_stall();
      test_boot_stall();
      test_fault_misaligned();
      test_fault_range();
      step(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
